// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX->MEM pipeline stage: 2-entry skid buffer with precise exception capture
module ex_mem_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] ex_result,
  input  logic [7:0]    ex_status,
  input  logic [DW-1:0] ex_store_data,
  input  logic [RW-1:0] ex_dest,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_reg_write,
  input  logic          ex_ovf_en,
  input  logic          flush,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [DW-1:0] mem_result,
  output logic [DW-1:0] mem_store_data,
  output logic [RW-1:0] mem_dest,
  output logic          mem_read,
  output logic          mem_write,
  output logic          mem_reg_write,
  output logic          exc_pending,
  output logic [4:0]    exc_code,
  output logic [DW-1:0] exc_badaddr,
  input  logic          exc_ack
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0] result;
    logic [DW-1:0] sdata;
    logic [RW-1:0] dest;
    logic          rd;
    logic          wr;
    logic          rw;
  } entry_t;

  localparam logic [4:0] EXC_OVF    = 5'h0C;
  localparam logic [4:0] EXC_LD_MIS = 5'h04;
  localparam logic [4:0] EXC_ST_MIS = 5'h05;

  state_t        r_state;
  state_t        w_state_nxt;
  entry_t        r_head;
  entry_t        r_sec;
  entry_t        w_new;
  logic          r_exc_pending;
  logic [4:0]    r_exc_code;
  logic [DW-1:0] r_exc_badaddr;

  logic w_ovf;
  logic w_mis;
  logic w_fault;
  logic w_valid;
  logic w_acc;
  logic w_cons;

  // Fault detection and the entry to enqueue; a faulting op keeps its data but loses all side effects
  always_comb begin
    w_ovf        = ex_status[6] & ex_ovf_en;
    w_mis        = ex_status[3] & (ex_mem_read | ex_mem_write);
    w_fault      = w_ovf | w_mis;
    w_new.result = ex_result;
    w_new.sdata  = ex_store_data;
    w_new.dest   = ex_dest;
    w_new.rd     = ex_mem_read  & ~w_fault;
    w_new.wr     = ex_mem_write & ~w_fault;
    w_new.rw     = ex_reg_write & ~w_fault;
  end

  assign w_valid  = (r_state != S_EMPTY);
  assign ex_ready = (r_state != S_TWO) & ~r_exc_pending & ~flush;
  assign w_acc    = ex_valid & ex_ready;
  assign w_cons   = w_valid & mem_ready & ~flush;

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Occupancy next-state: flush empties the buffer, otherwise track accept/consume
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_acc) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_acc && !w_cons)      w_state_nxt = S_TWO;
          else if (!w_acc && w_cons) w_state_nxt = S_EMPTY;
        end
        S_TWO:   if (w_cons) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Entry storage: head always holds the oldest op, second entry slides forward on consume
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_sec  <= '0;
    end else if (!flush) begin
      case (r_state)
        S_EMPTY: if (w_acc) r_head <= w_new;
        S_ONE: begin
          if (w_acc && w_cons) r_head <= w_new;
          else if (w_acc)      r_sec  <= w_new;
        end
        S_TWO:   if (w_cons) r_head <= r_sec;
        default: ;
      endcase
    end
  end

  // Exception record: set by an accepted faulting op, held until acknowledged; flush leaves it alone
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exc_pending <= 1'b0;
      r_exc_code    <= '0;
      r_exc_badaddr <= '0;
    end else if (w_acc && w_fault) begin
      r_exc_pending <= 1'b1;
      r_exc_code    <= w_ovf ? EXC_OVF : (ex_mem_read ? EXC_LD_MIS : EXC_ST_MIS);
      r_exc_badaddr <= ex_result;
    end else if (exc_ack && r_exc_pending) begin
      r_exc_pending <= 1'b0;
      r_exc_code    <= '0;
      r_exc_badaddr <= '0;
    end
  end

  assign mem_valid      = w_valid;
  assign mem_result     = w_valid ? r_head.result : '0;
  assign mem_store_data = w_valid ? r_head.sdata  : '0;
  assign mem_dest       = w_valid ? r_head.dest   : '0;
  assign mem_read       = w_valid & r_head.rd;
  assign mem_write      = w_valid & r_head.wr;
  assign mem_reg_write  = w_valid & r_head.rw;
  assign exc_pending    = r_exc_pending;
  assign exc_code       = r_exc_code;
  assign exc_badaddr    = r_exc_badaddr;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage with a queue-based reference model
module tb_ex_mem_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] ex_result;
  logic [7:0]    ex_status;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_dest;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_reg_write;
  logic          ex_ovf_en;
  logic          flush;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] mem_store_data;
  logic [RW-1:0] mem_dest;
  logic          mem_read;
  logic          mem_write;
  logic          mem_reg_write;
  logic          exc_pending;
  logic [4:0]    exc_code;
  logic [DW-1:0] exc_badaddr;
  logic          exc_ack;

  always #5 clk = ~clk;

  ex_mem_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_status(ex_status), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_ovf_en(ex_ovf_en), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_result(mem_result), .mem_store_data(mem_store_data), .mem_dest(mem_dest),
    .mem_read(mem_read), .mem_write(mem_write), .mem_reg_write(mem_reg_write),
    .exc_pending(exc_pending), .exc_code(exc_code), .exc_badaddr(exc_badaddr),
    .exc_ack(exc_ack)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rd;
    logic        wr;
    logic        rw;
  } ent_t;

  ent_t        mq[$];
  bit          m_pend;
  logic [4:0]  m_code;
  logic [31:0] m_bad;
  int          n_checks = 0;
  int          n_errs   = 0;
  bit          chk_en   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of at most two ops plus a single exception record
  always @(posedge clk) begin : model
    bit   acc, cons, ovf, mis, pend0;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_pend = 0;
      m_code = 0;
      m_bad  = 0;
    end else begin
      pend0 = m_pend;
      if (flush) begin
        mq.delete();
      end else begin
        acc  = ex_valid && (mq.size() < 2) && !pend0;
        cons = (mq.size() > 0) && mem_ready;
        if (cons) mq.delete(0);
        if (acc) begin
          ovf    = ex_status[6] && ex_ovf_en;
          mis    = ex_status[3] && (ex_mem_read || ex_mem_write);
          e.res  = ex_result;
          e.sd   = ex_store_data;
          e.dest = ex_dest;
          e.rd   = ex_mem_read  && !(ovf || mis);
          e.wr   = ex_mem_write && !(ovf || mis);
          e.rw   = ex_reg_write && !(ovf || mis);
          mq.push_back(e);
          if (ovf || mis) begin
            m_pend = 1;
            m_code = ovf ? 5'h0C : (ex_mem_read ? 5'h04 : 5'h05);
            m_bad  = ex_result;
          end
        end
      end
      if (exc_ack && pend0) begin
        m_pend = 0;
        m_code = 0;
        m_bad  = 0;
      end
    end
  end

  // Compare DUT against the model half a cycle after each edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_valid", {31'b0, mem_valid}, {31'b0, mq.size() > 0});
      if (mq.size() > 0) begin
        chk("mem_result", mem_result, mq[0].res);
        chk("mem_store_data", mem_store_data, mq[0].sd);
        chk("mem_dest", {27'b0, mem_dest}, {27'b0, mq[0].dest});
        chk("mem_read", {31'b0, mem_read}, {31'b0, mq[0].rd});
        chk("mem_write", {31'b0, mem_write}, {31'b0, mq[0].wr});
        chk("mem_reg_write", {31'b0, mem_reg_write}, {31'b0, mq[0].rw});
      end else begin
        chk("idle_enables", {29'b0, mem_read, mem_write, mem_reg_write}, 32'd0);
      end
      chk("ex_ready", {31'b0, ex_ready},
          {31'b0, (mq.size() < 2) && !m_pend && !flush});
      chk("exc_pending", {31'b0, exc_pending}, {31'b0, m_pend});
      if (m_pend) begin
        chk("exc_code", {27'b0, exc_code}, {27'b0, m_code});
        chk("exc_badaddr", exc_badaddr, m_bad);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] res, input logic [7:0] st,
                       input logic rd, input logic wr, input logic rw, input logic oe);
    ex_valid      = 1'b1;
    ex_result     = res;
    ex_status     = st;
    ex_store_data = res ^ 32'hA5A5_0000;
    ex_dest       = res[4:0];
    ex_mem_read   = rd;
    ex_mem_write  = wr;
    ex_reg_write  = rw;
    ex_ovf_en     = oe;
  endtask

  task automatic ack();
    ex_valid = 1'b0;
    exc_ack  = 1'b1;
    tick();
    exc_ack  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_result = '0; ex_status = '0; ex_store_data = '0;
    ex_dest = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
    ex_ovf_en = 1'b0; flush = 1'b0; mem_ready = 1'b0; exc_ack = 1'b0;
    tick();
    tick();
    chk_en = 1;
    reset  = 1'b0;
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_exc_pending", {31'b0, exc_pending}, 32'd0);
    chk("rst_exc_code", {27'b0, exc_code}, 32'd0);
    chk("rst_mem_result", mem_result, 32'd0);

    // single op, 1-cycle latency
    mem_ready = 1'b1;
    drive(32'h10, 8'h00, 0, 0, 1, 0);
    tick();
    ex_valid = 1'b0;
    chk("t1_valid", {31'b0, mem_valid}, 32'd1);
    chk("t1_result", mem_result, 32'h10);
    chk("t1_regwr", {31'b0, mem_reg_write}, 32'd1);
    tick();
    chk("t1_drain", {31'b0, mem_valid}, 32'd0);

    // fill to two entries, then drain in order
    mem_ready = 1'b0;
    drive(32'hA, 8'h00, 0, 0, 1, 0);
    tick();
    drive(32'hB, 8'h00, 0, 0, 1, 0);
    tick();
    drive(32'hC, 8'h00, 0, 0, 1, 0);
    chk("t2_full_ready", {31'b0, ex_ready}, 32'd0);
    tick();
    chk("t2_head_a", mem_result, 32'hA);
    mem_ready = 1'b1;
    tick();
    chk("t2_head_b", mem_result, 32'hB);
    tick();
    ex_valid = 1'b0;
    chk("t2_head_c", mem_result, 32'hC);
    tick();
    chk("t2_empty", {31'b0, mem_valid}, 32'd0);

    // misaligned load
    drive(32'h1002, 8'h08, 1, 0, 1, 0);
    tick();
    chk("t3_valid", {31'b0, mem_valid}, 32'd1);
    chk("t3_squash_rd", {31'b0, mem_read}, 32'd0);
    chk("t3_pend", {31'b0, exc_pending}, 32'd1);
    chk("t3_code", {27'b0, exc_code}, 32'h04);
    chk("t3_bad", exc_badaddr, 32'h1002);
    chk("t3_ready", {31'b0, ex_ready}, 32'd0);
    drive(32'h44, 8'h00, 0, 0, 1, 0);
    tick();
    chk("t3_blocked", {31'b0, mem_valid}, 32'd0);
    ack();
    chk("t3_acked", {31'b0, exc_pending}, 32'd0);
    chk("t3_ready_again", {31'b0, ex_ready}, 32'd1);

    // overflow beats misalign; without ovf_en the misalign wins
    drive(32'h2001, 8'h48, 0, 1, 0, 1);
    tick();
    ex_valid = 1'b0;
    chk("t4_ovf_code", {27'b0, exc_code}, 32'h0C);
    chk("t4_squash_wr", {31'b0, mem_write}, 32'd0);
    ack();
    drive(32'h2001, 8'h48, 0, 1, 0, 0);
    tick();
    ex_valid = 1'b0;
    chk("t4_st_mis_code", {27'b0, exc_code}, 32'h05);
    ack();
    drive(32'h7, 8'h40, 0, 0, 1, 0);
    tick();
    ex_valid = 1'b0;
    chk("t4_addu_nopend", {31'b0, exc_pending}, 32'd0);
    chk("t4_addu_regwr", {31'b0, mem_reg_write}, 32'd1);
    tick();

    // flush while full with a pending exception
    mem_ready = 1'b0;
    drive(32'h21, 8'h00, 0, 0, 1, 0);
    tick();
    drive(32'h22, 8'h40, 0, 0, 1, 1);
    tick();
    chk("t5_pend", {31'b0, exc_pending}, 32'd1);
    chk("t5_head", mem_result, 32'h21);
    flush = 1'b1;
    drive(32'h23, 8'h00, 0, 0, 1, 0);
    tick();
    flush    = 1'b0;
    ex_valid = 1'b0;
    chk("t5_flushed", {31'b0, mem_valid}, 32'd0);
    chk("t5_pend_kept", {31'b0, exc_pending}, 32'd1);
    chk("t5_code_kept", {27'b0, exc_code}, 32'h0C);
    tick();
    chk("t5_nothing_enq", {31'b0, mem_valid}, 32'd0);
    ack();

    // reset mid-operation drops entries and the exception
    drive(32'h3003, 8'h08, 1, 0, 1, 0);
    tick();
    ex_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    chk("t6_rst_pend", {31'b0, exc_pending}, 32'd0);
    chk("t6_rst_valid", {31'b0, mem_valid}, 32'd0);

    // mixed traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom, 8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
      ex_valid  = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      exc_ack   = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      tick();
    end
    ex_valid = 1'b0; flush = 1'b0; exc_ack = 1'b0; reset = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
